// File: rtl/dmem_ctrl.sv
// Single-port data memory with valid/ready request/response channels and configurable latency.
// Define DMEM_ALIGN_CHK_EN to fault misaligned accesses (resp_err); otherwise they are truncated.
module dmem_ctrl #(
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned DEPTH     = 8192,
    parameter int unsigned ADDR_W    = 64,
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
    parameter int unsigned LATENCY   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err
);

    localparam int unsigned NB   = DATA_W / 8;
    localparam int unsigned LW   = $clog2(NB);
    localparam int unsigned IW   = $clog2(DEPTH);
    localparam int unsigned DWL  = $clog2(DATA_W);
    localparam int unsigned CW   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [1:0]  MAX_SIZE = 2'(LW);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rword_q;
    logic [LW-1:0]     lane_q;
    logic [1:0]        size_q;
    logic              signed_q;
    logic              wen_q;
    logic              err_q;

    logic [ADDR_W-1:0] off;
    logic [LW-1:0]     lane;
    logic [IW-1:0]     idx;
    logic [1:0]        size_eff;
    logic [NB-1:0]     strobe;
    logic [DATA_W-1:0] wdata_sh;
    logic              fault;
    logic              acc;
    logic              do_write;
    logic              unused_off;

    always_comb begin
        off      = req_addr - ADDR_W'(BASE_ADDR);
        lane     = off[LW-1:0];
        idx      = off[LW +: IW];
        size_eff = (req_size > MAX_SIZE) ? MAX_SIZE : req_size;
        strobe   = NB'((1 << (1 << size_eff)) - 1) << lane;
        wdata_sh = req_wdata << (8 * lane);
`ifdef DMEM_ALIGN_CHK_EN
        fault    = (req_size > MAX_SIZE) || (|(lane & LW'((1 << size_eff) - 1)));
`else
        fault    = 1'b0;
`endif
        acc      = req_valid & req_ready;
        do_write = acc & req_wen & ~fault;
    end

    // Address bits above the word index alias silently.
    assign unused_off = ^off[ADDR_W-1:LW+IW];

    // Store commits on the accept edge, so a following load always sees it.
    always_ff @(posedge clk) begin
        if (acc) rword_q <= mem[idx];
        if (do_write) begin
            for (int b = 0; b < NB; b++) begin
                if (strobe[b]) mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
            end
        end
    end

    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] ext;
    logic [DWL-1:0]    msb;
    logic              sbit;

    always_comb begin
        shifted = rword_q >> (8 * lane_q);
        msb     = DWL'((8 << size_q) - 1);
        sbit    = signed_q & shifted[msb];
        ext     = '0;
        for (int b = 0; b < NB; b++) begin
            if (b < (1 << size_q)) ext[8*b +: 8] = shifted[8*b +: 8];
            else                   ext[8*b +: 8] = {8{sbit}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            lane_q     <= '0;
            size_q     <= '0;
            signed_q   <= 1'b0;
            wen_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (acc) begin
                        state     <= WAIT;
                        req_ready <= 1'b0;
                        cnt       <= '0;
                        lane_q    <= lane;
                        size_q    <= size_eff;
                        signed_q  <= req_signed;
                        wen_q     <= req_wen;
                        err_q     <= fault;
                    end
                end
                WAIT: begin
                    if (cnt == CW'(LATENCY - 1)) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= err_q;
                        resp_rdata <= (wen_q | err_q) ? '0 : ext;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        resp_rdata <= '0;
                        resp_err   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: 64-bit words, 16-word RAM, read latency 3.
module tb_dmem_ctrl;

    localparam int unsigned LAT  = 3;
    localparam int unsigned DEP  = 16;
    localparam logic [63:0] BASE = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [63:0] req_addr;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;

    int checks   = 0;
    int failures = 0;

    dmem_ctrl #(
        .DATA_W   (64),
        .DEPTH    (DEP),
        .ADDR_W   (64),
        .BASE_ADDR(BASE),
        .LATENCY  (LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wen   (req_wen),
        .req_addr  (req_addr),
        .req_size  (req_size),
        .req_signed(req_signed),
        .req_wdata (req_wdata),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_rdata(resp_rdata),
        .resp_err  (resp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic wen, input logic [63:0] addr, input logic [1:0] size,
                         input logic sgn, input logic [63:0] wdata);
        req_valid  = 1'b1;
        req_wen    = wen;
        req_addr   = addr;
        req_size   = size;
        req_signed = sgn;
        req_wdata  = wdata;
        @(posedge clk);
        #1;
        // Scramble request fields: the DUT must have captured them at accept.
        req_valid  = 1'b0;
        req_wen    = ~wen;
        req_addr   = {$urandom, $urandom};
        req_size   = ~size;
        req_signed = ~sgn;
        req_wdata  = {$urandom, $urandom};
    endtask

    task automatic xact(input string tag, input logic wen, input logic [63:0] addr,
                        input logic [1:0] size, input logic sgn, input logic [63:0] wdata,
                        input int hold, input logic [63:0] exp_rdata, input logic exp_err);
        int n;
        chk({tag, " req_ready before"}, {63'd0, req_ready}, 64'd1);
        drive(wen, addr, size, sgn, wdata);
        chk({tag, " req_ready busy"}, {63'd0, req_ready}, 64'd0);
        n = 0;
        while (!resp_valid && n < LAT + 5) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, " latency"}, 64'(n), 64'(LAT));
        for (int i = 0; i < hold; i++) begin
            chk({tag, " hold valid"}, {63'd0, resp_valid}, 64'd1);
            chk({tag, " hold rdata"}, resp_rdata, exp_rdata);
            chk({tag, " hold req_ready"}, {63'd0, req_ready}, 64'd0);
            @(posedge clk);
            #1;
        end
        chk({tag, " rdata"}, resp_rdata, exp_rdata);
        chk({tag, " err"}, {63'd0, resp_err}, {63'd0, exp_err});
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        chk({tag, " valid after hs"}, {63'd0, resp_valid}, 64'd0);
        chk({tag, " req_ready after hs"}, {63'd0, req_ready}, 64'd1);
    endtask

    task automatic reset_in_wait(input string tag, input logic wen, input logic [63:0] addr,
                                 input logic [63:0] wdata);
        logic seen;
        drive(wen, addr, 2'd3, 1'b0, wdata);
        rst_n = 1'b0;
        #1;
        chk({tag, " valid in reset"}, {63'd0, resp_valid}, 64'd0);
        chk({tag, " req_ready in reset"}, {63'd0, req_ready}, 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (resp_valid) seen = 1'b1;
        end
        chk({tag, " no response"}, {63'd0, seen}, 64'd0);
        chk({tag, " req_ready after"}, {63'd0, req_ready}, 64'd1);
    endtask

    logic [63:0] e_h3, e_x3, e_w1;
    logic        e_err;

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_wen    = 1'b0;
        req_addr   = '0;
        req_size   = '0;
        req_signed = 1'b0;
        req_wdata  = '0;
        resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset req_ready", {63'd0, req_ready}, 64'd1);
        chk("reset resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("reset resp_rdata", resp_rdata, 64'd0);
        chk("reset resp_err", {63'd0, resp_err}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        xact("st d0", 1, BASE, 2'd3, 0, 64'h1122_3344_5566_7788, 0, 64'd0, 0);
        xact("ld d0", 0, BASE, 2'd3, 0, 64'h0, 4, 64'h1122_3344_5566_7788, 0);

        xact("st b5", 1, BASE + 5, 2'd0, 0, 64'h5555_5555_5555_55AB, 0, 64'd0, 0);
        xact("ld b5 s", 0, BASE + 5, 2'd0, 1, 64'h0, 0, 64'hFFFF_FFFF_FFFF_FFAB, 0);
        xact("ld b5 u", 0, BASE + 5, 2'd0, 0, 64'h0, 0, 64'h0000_0000_0000_00AB, 0);
        xact("ld d0 b5", 0, BASE, 2'd3, 0, 64'h0, 0, 64'h1122_AB44_5566_7788, 0);

`ifdef DMEM_ALIGN_CHK_EN
        e_h3 = 64'd0;
        e_x3 = 64'd0;
        e_w1 = 64'hCAFE_BABE_8765_4321;
        e_err = 1'b1;
`else
        e_h3 = 64'h0000_0000_0000_4455;
        e_x3 = 64'h0000_0000_CAFE_BABE;
        e_w1 = 64'h5678_BABE_8765_4321;
        e_err = 1'b0;
`endif
        xact("ld h3 mis", 0, BASE + 3, 2'd1, 0, 64'h0, 0, e_h3, e_err);

        xact("st d1", 1, BASE + 8, 2'd3, 0, 64'hCAFE_BABE_8765_4321, 0, 64'd0, 0);
        xact("ld w12 s", 0, BASE + 12, 2'd2, 1, 64'h0, 0, 64'hFFFF_FFFF_CAFE_BABE, 0);
        xact("ld h10 u", 0, BASE + 10, 2'd1, 0, 64'h0, 0, 64'h0000_0000_0000_8765, 0);
        xact("ld h10 s", 0, BASE + 10, 2'd1, 1, 64'h0, 0, 64'hFFFF_FFFF_FFFF_8765, 0);
        xact("ld d12 cross", 0, BASE + 12, 2'd3, 0, 64'h0, 0, e_x3, e_err);
        xact("st w14 cross", 1, BASE + 14, 2'd2, 0, 64'h1234_5678, 0, 64'd0, e_err);
        xact("ld d1 after cross", 0, BASE + 8, 2'd3, 0, 64'h0, 0, e_w1, 0);

        xact("st alias", 1, BASE + 8 * DEP, 2'd3, 0, 64'hDEAD_BEEF_0BAD_F00D, 0, 64'd0, 0);
        xact("ld alias", 0, BASE, 2'd3, 0, 64'h0, 0, 64'hDEAD_BEEF_0BAD_F00D, 0);

        reset_in_wait("rst st", 1, BASE + 16, 64'h0123_4567_89AB_CDEF);
        xact("ld after rst st", 0, BASE + 16, 2'd3, 0, 64'h0, 0, 64'h0123_4567_89AB_CDEF, 0);
        reset_in_wait("rst ld", 0, BASE, 64'h0);
        xact("ld after rst ld", 0, BASE, 2'd3, 0, 64'h0, 0, 64'hDEAD_BEEF_0BAD_F00D, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
